// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode encodings, microstep constants and control word shared by the sequencer.
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'he,
    OP_HLT = 4'hf
  } opcode_e;

  localparam logic [2:0] STEP_T0 = 3'd0;
  localparam logic [2:0] STEP_T1 = 3'd1;
  localparam logic [2:0] STEP_T2 = 3'd2;
  localparam logic [2:0] STEP_T3 = 3'd3;
  localparam logic [2:0] STEP_T4 = 3'd4;

  typedef struct packed {
    logic pc_out;
    logic ir_out;
    logic ram_out;
    logic a_out;
    logic alu_out;
    logic mar_in;
    logic ir_in;
    logic ram_in;
    logic a_in;
    logic b_in;
    logic out_in;
    logic pc_inc;
    logic pc_load;
    logic alu_sub;
    logic flags_in;
  } ctrl_word_t;

  // Undefined opcodes fall through to the fetch-only length of NOP.
  function automatic logic [2:0] last_step(opcode_e op);
    case (op)
      OP_LDA, OP_STA: last_step = STEP_T3;
      OP_ADD, OP_SUB: last_step = STEP_T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = STEP_T2;
      default: last_step = STEP_T1;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_microcode_rom.sv
// ctrl_microcode_rom: combinational decode of (opcode, step, flags) into one control word.
module ctrl_microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  opcode_e    opcode,
  input  logic [2:0] step,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output ctrl_word_t word
);
  logic t2, t3, t4;
  assign t2 = step == STEP_T2;
  assign t3 = step == STEP_T3;
  assign t4 = step == STEP_T4;
  always_comb begin
    word = '0;
    if (step == STEP_T0) begin
      word.pc_out = 1'b1;
      word.mar_in = 1'b1;
    end else if (step == STEP_T1) begin
      word.ram_out = 1'b1;
      word.ir_in   = 1'b1;
      word.pc_inc  = 1'b1;
    end else begin
      case (opcode)
        OP_LDA: begin
          word.ir_out  = t2;
          word.mar_in  = t2;
          word.ram_out = t3;
          word.a_in    = t3;
        end
        OP_ADD, OP_SUB: begin
          word.ir_out   = t2;
          word.mar_in   = t2;
          word.ram_out  = t3;
          word.b_in     = t3;
          word.alu_out  = t4;
          word.a_in     = t4;
          word.flags_in = t4;
          word.alu_sub  = t4 && opcode == OP_SUB;
        end
        OP_STA: begin
          word.ir_out = t2;
          word.mar_in = t2;
          word.a_out  = t3;
          word.ram_in = t3;
        end
        OP_LDI: begin
          word.ir_out = t2;
          word.a_in   = t2;
        end
        OP_JMP: begin
          word.ir_out  = t2;
          word.pc_load = t2;
        end
        OP_JC: begin
          word.ir_out  = t2 && flag_carry;
          word.pc_load = t2 && flag_carry;
        end
        OP_JZ: begin
          word.ir_out  = t2 && flag_zero;
          word.pc_load = t2 && flag_zero;
        end
        OP_OUT: begin
          word.a_out  = t2;
          word.out_in = t2;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bus_control_sequencer.sv
// bus_control_sequencer: step counter and sticky halt driving the microcoded bus control word.
module bus_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flag_carry,
  input  logic              flag_zero,
  output logic [STEP_W-1:0] step,
  output logic              halt,
  output logic              pc_out,
  output logic              ir_out,
  output logic              ram_out,
  output logic              a_out,
  output logic              alu_out,
  output logic              mar_in,
  output logic              ir_in,
  output logic              ram_in,
  output logic              a_in,
  output logic              b_in,
  output logic              out_in,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              alu_sub,
  output logic              flags_in
);
  logic [STEP_W-1:0] step_q;
  logic              halted;
  logic              hlt_now;
  logic              wrap;
  opcode_e           op;
  ctrl_word_t        rom_word, word;

  assign op = opcode_e'(opcode);

  ctrl_microcode_rom u_rom (
    .opcode    (op),
    .step      (step_q),
    .flag_carry(flag_carry),
    .flag_zero (flag_zero),
    .word      (rom_word)
  );

  assign hlt_now = !halted && step_q == STEP_T2 && op == OP_HLT;
  assign wrap    = halted || step_q >= last_step(op) || step_q >= STEP_T4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      halted <= 1'b0;
    end else begin
      step_q <= wrap ? '0 : step_q + 1'b1;
      halted <= halted || hlt_now;
    end
  end

  // Reset gates the outputs combinationally so they drop without waiting for an edge.
  assign word = (rst_n && !halted) ? rom_word : '0;
  assign halt = rst_n && (halted || hlt_now);
  assign step = step_q;
  assign {pc_out, ir_out, ram_out, a_out, alu_out, mar_in, ir_in, ram_in,
          a_in, b_in, out_in, pc_inc, pc_load, alu_sub, flags_in} = word;

  bus_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({pc_out, ir_out, ram_out, a_out, alu_out}) &&
    !(pc_out && pc_load) && !(ir_out && ir_in) &&
    !(ram_out && ram_in) && !(a_out && a_in));
endmodule
